// File: rtl/run_dump_controller.sv
// run_dump_controller
//   End-of-run monitor for the Processador core. Watches the fetch stream
//   for a halt (sentinel instruction or invalid fetch, or an optional cycle
//   timeout), waits a drain interval so in-flight writes settle, then walks
//   the register file followed by the data memory through their async read
//   ports. Each entry is offered on a valid/ready dump channel.
//
//   Optional feature macro: DUMP_SKIP_ZERO_EN
//     When defined, entries whose read data is zero are not presented; the
//     walk still spends one cycle on each of them.
module run_dump_controller #(
    parameter int                 DATA_W       = 32,
    parameter int                 INSTR_W      = 32,
    parameter int                 NUM_REGS     = 32,
    parameter int                 MEM_DEPTH    = 64,
    parameter logic [INSTR_W-1:0] HALT_INSTR   = {INSTR_W{1'b0}},
    parameter int                 DRAIN_CYCLES = 5,
    parameter int                 TIMEOUT      = 0,
    localparam int RA_W  = $clog2(NUM_REGS),
    localparam int MA_W  = $clog2(MEM_DEPTH),
    localparam int IDX_W = $clog2(MEM_DEPTH > NUM_REGS ? MEM_DEPTH : NUM_REGS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_valid,
    output logic [RA_W-1:0]    reg_rd_addr,
    input  logic [DATA_W-1:0]  reg_rd_data,
    output logic [MA_W-1:0]    mem_rd_addr,
    input  logic [DATA_W-1:0]  mem_rd_data,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic               dump_is_mem,
    output logic [IDX_W-1:0]   dump_index,
    output logic [DATA_W-1:0]  dump_data,
    output logic               halted,
    output logic               done,
    output logic               timed_out,
    output logic [31:0]        cycle_count
);

    localparam int               DC_W     = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DC_W-1:0]  DRAIN_M1 = DC_W'(DRAIN_CYCLES - 1);
    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_DEPTH - 1);
    localparam bit               TO_EN    = (TIMEOUT != 0);
    localparam logic [31:0]      TO_M1    = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_DUMP_REG,
        S_DUMP_MEM,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   index_q;
    logic [DC_W-1:0]    drain_q;
    logic [31:0]        cycle_q;
    logic               timed_out_q;
    // A word that was offered but not taken is frozen here so the sink
    // sees it unchanged even if the backing storage changes underneath.
    logic               hold_vld_q;
    logic [DATA_W-1:0]  hold_data_q;

    logic               halt_now;
    logic               force_now;
    logic               drain_last;
    logic               in_dump;
    logic [DATA_W-1:0]  src_data;
    logic               src_zero;
    logic               present;
    logic               advance;
    logic               idx_last;

    // Halt sources: a real halt always wins over a coincident timeout.
    always_comb begin
        halt_now  = 1'b0;
        force_now = 1'b0;
        if (state_q == S_RUN) begin
            halt_now  = !instr_valid || (instr_in == HALT_INSTR);
            force_now = TO_EN && (cycle_q == TO_M1) && !halt_now;
        end
    end

    // Dump datapath: read-port addressing, presentation and handshake.
    always_comb begin
        in_dump     = (state_q == S_DUMP_REG) || (state_q == S_DUMP_MEM);
        dump_is_mem = (state_q == S_DUMP_MEM);
        reg_rd_addr = '0;
        mem_rd_addr = '0;
        src_data    = '0;
        if (state_q == S_DUMP_REG) begin
            reg_rd_addr = index_q[RA_W-1:0];
            src_data    = reg_rd_data;
        end else if (state_q == S_DUMP_MEM) begin
            mem_rd_addr = index_q[MA_W-1:0];
            src_data    = mem_rd_data;
        end
`ifdef DUMP_SKIP_ZERO_EN
        src_zero = (src_data == '0);
`else
        src_zero = 1'b0;
`endif
        // An already-offered word stays offered until it is taken.
        present    = hold_vld_q || !src_zero;
        dump_valid = in_dump && present;
        dump_data  = '0;
        if (in_dump)
            dump_data = hold_vld_q ? hold_data_q : src_data;
        dump_index = index_q;
        // Skipped entries advance unconditionally; presented ones need ready.
        advance    = in_dump && (present ? dump_ready : 1'b1);
        idx_last   = (state_q == S_DUMP_MEM) ? (index_q == MEM_LAST)
                                             : (index_q == REG_LAST);
        drain_last = (drain_q == DRAIN_M1);
        halted     = (state_q != S_RUN);
        done       = (state_q == S_DONE);
        timed_out  = timed_out_q;
        cycle_count = cycle_q;
    end

    // Next-state logic for the run / drain / dump sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:      if (halt_now || force_now)  state_d = S_DRAIN;
            S_DRAIN:    if (drain_last)             state_d = S_DUMP_REG;
            S_DUMP_REG: if (advance && idx_last)    state_d = S_DUMP_MEM;
            S_DUMP_MEM: if (advance && idx_last)    state_d = S_DONE;
            default:                                state_d = state_q;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset)
            state_q <= S_RUN;
        else
            state_q <= state_d;
    end

    // Run-cycle counter: counts RUN cycles that do not end the run, saturating.
    always_ff @(posedge clock) begin
        if (reset)
            cycle_q <= '0;
        else if (state_q == S_RUN && !halt_now && !force_now && cycle_q != '1)
            cycle_q <= cycle_q + 32'd1;
    end

    // Timeout flag, sticky until reset.
    always_ff @(posedge clock) begin
        if (reset)
            timed_out_q <= 1'b0;
        else if (force_now)
            timed_out_q <= 1'b1;
    end

    // Drain interval counter, cleared whenever not draining.
    always_ff @(posedge clock) begin
        if (reset || state_q != S_DRAIN)
            drain_q <= '0;
        else
            drain_q <= drain_q + DC_W'(1);
    end

    // Entry index: wraps to 0 at the reg->mem and mem->done boundaries.
    always_ff @(posedge clock) begin
        if (reset)
            index_q <= '0;
        else if (advance)
            index_q <= idx_last ? '0 : index_q + IDX_W'(1);
    end

    // Stall capture: freeze an offered word until the sink takes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
        end else if (!in_dump || advance) begin
            hold_vld_q  <= 1'b0;
        end else if (dump_valid && !dump_ready) begin
            hold_vld_q  <= 1'b1;
            hold_data_q <= dump_data;
        end
    end

endmodule
